// File: rtl/mtl_avalon_cmd_master_if.sv
// Avalon-MM bus between the command master and the MTL register slave.
// The master modport drives address/strobes/writedata; the slave modport
// drives waitrequest and readdata.
interface mtl_avalon_cmd_master_if;
    logic [7:0]  Avalon_m_address;
    logic        Avalon_m_read;
    logic        Avalon_m_write;
    logic [31:0] Avalon_m_writedata;
    logic        Avalon_m_waitrequest;
    logic [31:0] Avalon_m_readdata;

    modport master (
        output Avalon_m_address,
        output Avalon_m_read,
        output Avalon_m_write,
        output Avalon_m_writedata,
        input  Avalon_m_waitrequest,
        input  Avalon_m_readdata
    );

    modport slave (
        input  Avalon_m_address,
        input  Avalon_m_read,
        input  Avalon_m_write,
        input  Avalon_m_writedata,
        output Avalon_m_waitrequest,
        output Avalon_m_readdata
    );
endinterface

// File: rtl/mtl_avalon_cmd_master.sv
// Avalon-MM command master for the MTL controller register slave.
// Commands are queued in a FIFO and issued one at a time. The bus strobe is
// held until the slave accepts it (or the stall timer expires), reads wait a
// fixed latency for data, and every command yields exactly one response pulse.
module mtl_avalon_cmd_master #(
    parameter int DEPTH        = 8,    // power of two, >= 2
    parameter int READ_LATENCY = 1,    // 1..4
    parameter int TIMEOUT      = 255   // >= 1
) (
    input  logic        Avalon_CLK_50,
    input  logic        Avalon_reset,

    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [7:0]  cmd_address,
    input  logic [31:0] cmd_writedata,

    output logic        rsp_valid,
    output logic        rsp_write,
    output logic        rsp_timeout,
    output logic [31:0] rsp_readdata,
    output logic        busy,

    mtl_avalon_cmd_master_if.master avm
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam int LW = $clog2(READ_LATENCY + 1);

    localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
    localparam logic [WW-1:0] WAIT_LAST  = WW'(TIMEOUT - 1);
    localparam logic [LW-1:0] LAT_INIT   = LW'(READ_LATENCY);
    localparam logic [LW-1:0] LAT_LAST   = LW'(1);

    typedef struct packed {
        logic        write;
        logic [7:0]  address;
        logic [31:0] writedata;
    } cmd_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_RDWAIT,
        S_RESP
    } state_e;

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    cmd_t          mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          cmd_ready_q, cmd_ready_d;
    logic          push, pop;
    cmd_t          cmd_in;

    // ------------------------------------------------------------------
    // Transfer FSM state
    // ------------------------------------------------------------------
    state_e        state_q, state_d;
    cmd_t          hold_q, hold_d;
    logic [WW-1:0] wait_q, wait_d;
    logic [LW-1:0] lat_q, lat_d;
    logic          rsp_write_q,    rsp_write_d;
    logic          rsp_timeout_q,  rsp_timeout_d;
    logic [31:0]   rsp_readdata_q, rsp_readdata_d;

    assign cmd_in = '{write: cmd_write, address: cmd_address, writedata: cmd_writedata};

    // The holding register is only loaded in IDLE, so popping here keeps at
    // most one transfer in flight while the next command waits in the FIFO.
    assign push = cmd_valid && cmd_ready_q;
    assign pop  = (state_q == S_IDLE) && (count_q != '0);

    // FIFO pointer and occupancy next-state; pointers wrap naturally mod DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // cmd_ready is registered so it reflects the occupancy after this edge.
        cmd_ready_d = (count_d < DEPTH_C);
    end

    // FIFO storage write.
    // NOTE: storage is not reset; only the pointers and count define validity,
    // so clearing the array would add reset fan-out for no functional gain.
    always_ff @(posedge Avalon_CLK_50) begin
        if (push) begin
            mem_q[wr_ptr_q] <= cmd_in;
        end
    end

    // FSM next-state and response capture.
    // NOTE: every variable gets its default before the case statement so no
    // path leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d        = state_q;
        hold_d         = hold_q;
        wait_d         = wait_q;
        lat_d          = lat_q;
        rsp_write_d    = rsp_write_q;
        rsp_timeout_d  = rsp_timeout_q;
        rsp_readdata_d = rsp_readdata_q;

        unique case (state_q)
            S_IDLE: begin
                if (pop) begin
                    hold_d  = mem_q[rd_ptr_q];
                    wait_d  = '0;
                    state_d = S_ISSUE;
                end
            end

            S_ISSUE: begin
                if (!avm.Avalon_m_waitrequest) begin
                    if (hold_q.write) begin
                        rsp_write_d    = 1'b1;
                        rsp_timeout_d  = 1'b0;
                        rsp_readdata_d = '0;
                        state_d        = S_RESP;
                    end else begin
                        lat_d   = LAT_INIT;
                        state_d = S_RDWAIT;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    // Stalled for TIMEOUT cycles: abandon the strobe.
                    rsp_write_d    = hold_q.write;
                    rsp_timeout_d  = 1'b1;
                    rsp_readdata_d = '0;
                    state_d        = S_RESP;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end

            S_RDWAIT: begin
                // Data is valid READ_LATENCY cycles after the accepting edge.
                if (lat_q == LAT_LAST) begin
                    rsp_write_d    = 1'b0;
                    rsp_timeout_d  = 1'b0;
                    rsp_readdata_d = avm.Avalon_m_readdata;
                    state_d        = S_RESP;
                end else begin
                    lat_d = lat_q - 1'b1;
                end
            end

            S_RESP: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, pointer and response registers with synchronous reset.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge Avalon_CLK_50) begin
        if (Avalon_reset) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            cmd_ready_q    <= 1'b1;
            state_q        <= S_IDLE;
            hold_q         <= '0;
            wait_q         <= '0;
            lat_q          <= '0;
            rsp_write_q    <= 1'b0;
            rsp_timeout_q  <= 1'b0;
            rsp_readdata_q <= '0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            cmd_ready_q    <= cmd_ready_d;
            state_q        <= state_d;
            hold_q         <= hold_d;
            wait_q         <= wait_d;
            lat_q          <= lat_d;
            rsp_write_q    <= rsp_write_d;
            rsp_timeout_q  <= rsp_timeout_d;
            rsp_readdata_q <= rsp_readdata_d;
        end
    end

    // Outputs decode directly from registers; the strobe is a function of
    // state and the held command only, so read and write are never both high.
    assign cmd_ready              = cmd_ready_q;
    assign avm.Avalon_m_address   = hold_q.address;
    assign avm.Avalon_m_writedata = hold_q.writedata;
    assign avm.Avalon_m_write     = (state_q == S_ISSUE) &&  hold_q.write;
    assign avm.Avalon_m_read      = (state_q == S_ISSUE) && !hold_q.write;

    assign rsp_valid    = (state_q == S_RESP);
    assign rsp_write    = rsp_write_q;
    assign rsp_timeout  = rsp_timeout_q;
    assign rsp_readdata = rsp_readdata_q;
    assign busy         = (count_q != '0) || (state_q != S_IDLE);

endmodule
